ascon_ctrl_fsm: RTL and testbench
=================================

Name: ascon_ctrl_fsm

Overview:
- Control state machine for the ASCON-128 encryption datapath. It sits directly upstream of the iterated permutation/XOR stage and drives that stage's controls every cycle:
  - input mux select
  - round index
  - XOR-up enable
  - XOR-down enable and operand mode
  - state register enable
- Sequences the full encryption: initialisation (p12), one associated-data block (p6), NB_BLOCKS plaintext blocks (p6 between blocks), finalisation (p12) and tag release.
- Plaintext/AD arrive over a valid/ready handshake. The top level builds the XOR operands from xor_down_mode_o.

Parameters:
- NB_BLOCKS, 4, number of 64-bit plaintext blocks per message; legal range 2..15.

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  start a new encryption; accepted only in IDLE
- data_valid_i  in  1  AD/plaintext block present on the datapath XOR-up bus
- block_ready_o  out  1  FSM waiting for an AD/plaintext block
- select_o  out  1  1 = load initial state into the permutation stage; 0 = iterate
- round_o  out  4  round index for the constant-addition layer
- ena_xor_up_o  out  1  XOR data block into x0 before the round
- ena_xor_down_o  out  1  XOR 256-bit operand into x1..x4 after the round
- xor_down_mode_o  out  2  down-operand selector: 00 none, 01 DSEP (256'h1), 10 KEY_HI ({K,128'h0}), 11 KEY_LO ({128'h0,K})
- ena_reg_o  out  1  permutation state register enable
- cipher_valid_o  out  1  xor-up output x0 is a valid ciphertext block this cycle
- block_idx_o  out  4  index of the current plaintext block (0..NB_BLOCKS-1)
- tag_valid_o  out  1  x3,x4 of the permutation output hold the tag this cycle
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_i=1):
  - State goes to IDLE and the round counter and block counter are cleared to 0.
  - Every output is 0. Mid-operation reset aborts the message; there is no partial completion.
- All datapath controls are Mealy: combinational from state, counter and inputs. The handshake cycle is therefore the first round cycle, and the top only needs to hold data during that cycle.
- Transfer = block_ready_o & data_valid_i. data_valid_i is ignored outside WAIT states. start_i is ignored outside IDLE.
- States:
  - IDLE: if start_i, then select_o=1, round_o=0, ena_reg_o=1, and go to INIT with counter=1. Otherwise all controls are 0.
  - INIT: round_o=counter (1..11), ena_reg_o=1. At counter 11: ena_xor_down_o=1, mode=KEY_LO, then go to WAIT_AD.
  - WAIT_AD: block_ready_o=1. On transfer: round_o=6, ena_xor_up_o=1, ena_reg_o=1, counter=7, go to PB_AD. Without transfer: ena_reg_o=0, state held.
  - PB_AD: round_o=counter (7..11), ena_reg_o=1. At round 11: ena_xor_down_o=1, mode=DSEP, go to WAIT_PT with block_idx=0.
  - WAIT_PT: block_ready_o=1.
    - On transfer with block_idx < NB_BLOCKS-1: cipher_valid_o=1, ena_xor_up_o=1, round_o=6, ena_reg_o=1, go to PB_PT.
    - On transfer with block_idx = NB_BLOCKS-1: cipher_valid_o=1, ena_xor_up_o=1, round_o=0, ena_reg_o=1, go to FINAL with counter=1.
  - PB_PT: rounds 7..11. At round 11: block_idx increments, and if the new block_idx = NB_BLOCKS-1 then ena_xor_down_o=1 with mode=KEY_HI (key pre-added to x1,x2 ahead of finalisation); otherwise no XOR-down. Then go to WAIT_PT.
  - FINAL: rounds 1..11. At round 11: ena_xor_down_o=1, mode=KEY_LO, tag_valid_o=1, go to DONE.
  - DONE: one cycle, all controls 0, then go to IDLE. busy_o is low from the cycle after DONE.
- round_o is 0 whenever ena_reg_o=0.
- ena_xor_down_o=0 implies xor_down_mode_o=00.
- The counter never wraps within a phase.
- block_idx_o holds its value in WAIT_PT and clears in IDLE.
- Minimum latency, start to tag_valid_o, with data always valid: 12 + 6 + 6·(NB_BLOCKS-1) + 12 cycles. For NB_BLOCKS=4 that is tag_valid_o in cycle 47, counting the start cycle as 0.

Test Plan:
- Reset then start_i pulse, data_valid_i held 1, NB_BLOCKS=4:
  - round_o sequence is 0..11, 6..11, (6..11)x3, 0..11.
  - cipher_valid_o high in cycles 18, 24, 30, 36.
  - tag_valid_o high in cycle 47; busy_o falls in cycle 49.
- data_valid_i low for 5 cycles in WAIT_AD → block_ready_o stays 1, ena_reg_o=0 and round_o=0 throughout; resumes with round 6 on the transfer cycle.
- Check XOR-down modes across a full message:
  - KEY_LO at init round 11.
  - DSEP at AD round 11.
  - KEY_HI only at the end of the PB_PT that leads into the last block (block_idx 2→3 for NB_BLOCKS=4).
  - KEY_LO together with tag_valid_o.
- start_i asserted during PB_PT and data_valid_i pulsed during INIT → no effect on state, round sequence or block_idx_o.
- reset_i asserted asynchronously mid-FINAL (e.g. round 5) → all outputs 0 immediately; a subsequent start_i produces the full sequence from round 0.
- NB_BLOCKS=2 → single PB_PT whose round 11 carries KEY_HI; FINAL entered on the second transfer; tag_valid_o in cycle 35 with continuous valid.

Source files
------------

// File: rtl/ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm
//
// Control state machine for an iterated ASCON-128 encryption datapath. Every
// cycle it drives the permutation stage controls (input select, round index,
// XOR-up / XOR-down enables, down-operand mode, state register enable) and
// sequences: p12 initialisation, one associated-data block followed by p6,
// NB_BLOCKS plaintext blocks with p6 between them, p12 finalisation and tag
// release.
//
// All datapath controls are Mealy outputs: the handshake cycle of a data
// block is also the first round applied to it, so the top level only has to
// hold the block on its XOR-up bus during that single cycle.
//
// Ports
//   clock_i          in   system clock, rising edge
//   reset_i          in   asynchronous active-high reset
//   start_i          in   start a new encryption (honoured only in IDLE)
//   data_valid_i     in   AD/plaintext block present on the XOR-up bus
//   block_ready_o    out  waiting for an AD/plaintext block
//   select_o         out  1 = load initial state, 0 = iterate
//   round_o[3:0]     out  round index for the constant-addition layer
//   ena_xor_up_o     out  XOR data block into x0 before the round
//   ena_xor_down_o   out  XOR 256-bit operand into x1..x4 after the round
//   xor_down_mode_o  out  00 none, 01 DSEP, 10 KEY_HI, 11 KEY_LO
//   ena_reg_o        out  permutation state register enable
//   cipher_valid_o   out  x0 after XOR-up is a ciphertext block this cycle
//   block_idx_o[3:0] out  index of the current plaintext block
//   tag_valid_o      out  x3,x4 of the permutation output hold the tag
//   busy_o           out  state is not IDLE
// ---------------------------------------------------------------------------
module ascon_ctrl_fsm #(
  parameter int unsigned NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       block_ready_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] xor_down_mode_o,
  output logic       ena_reg_o,
  output logic       cipher_valid_o,
  output logic [3:0] block_idx_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_PB_AD   = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PB_PT   = 3'd5,
    ST_FINAL   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] LAST_IDX   = 4'(NB_BLOCKS - 1);
  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_DSEP  = 2'b01;
  localparam logic [1:0] MODE_KHI   = 2'b10;
  localparam logic [1:0] MODE_KLO   = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] r_block_idx;
  logic [3:0] w_block_idx_nxt;
  logic [3:0] w_block_idx_inc;
  logic       w_start;

  // A start seen while reset is still asserted must not leak onto the
  // Mealy outputs: every control stays low for the whole reset.
  assign w_start         = start_i & ~reset_i;
  assign w_block_idx_inc = r_block_idx + 4'd1;
  assign block_idx_o     = r_block_idx;

  // State, round counter and block index registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_block_idx <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_block_idx <= w_block_idx_nxt;
    end
  end

  // Next-state logic and Mealy datapath controls.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_block_idx_nxt = r_block_idx;
    block_ready_o   = 1'b0;
    select_o        = 1'b0;
    round_o         = 4'd0;
    ena_xor_up_o    = 1'b0;
    ena_xor_down_o  = 1'b0;
    xor_down_mode_o = MODE_NONE;
    ena_reg_o       = 1'b0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    busy_o          = 1'b1;

    case (r_state)
      ST_IDLE: begin
        busy_o          = 1'b0;
        w_block_idx_nxt = 4'd0;
        if (w_start) begin
          // Round 0 of p12 is applied while the initial state is loaded.
          select_o    = 1'b1;
          ena_reg_o   = 1'b1;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = ST_INIT;
        end else begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_INIT: begin
        round_o   = r_cnt;
        ena_reg_o = 1'b1;
        if (r_cnt == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          xor_down_mode_o = MODE_KLO;
          w_state_nxt     = ST_WAIT_AD;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_WAIT_AD: begin
        block_ready_o = 1'b1;
        if (data_valid_i) begin
          // Transfer cycle doubles as round 6 of p6.
          round_o      = 4'd6;
          ena_xor_up_o = 1'b1;
          ena_reg_o    = 1'b1;
          w_cnt_nxt    = 4'd7;
          w_state_nxt  = ST_PB_AD;
        end else begin
          w_state_nxt = ST_WAIT_AD;
        end
      end

      ST_PB_AD: begin
        round_o   = r_cnt;
        ena_reg_o = 1'b1;
        if (r_cnt == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          xor_down_mode_o = MODE_DSEP;
          w_block_idx_nxt = 4'd0;
          w_state_nxt     = ST_WAIT_PT;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_WAIT_PT: begin
        block_ready_o = 1'b1;
        if (data_valid_i) begin
          cipher_valid_o = 1'b1;
          ena_xor_up_o   = 1'b1;
          ena_reg_o      = 1'b1;
          if (r_block_idx == LAST_IDX) begin
            // Last block goes straight into p12: this cycle is its round 0.
            round_o     = 4'd0;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_FINAL;
          end else begin
            round_o     = 4'd6;
            w_cnt_nxt   = 4'd7;
            w_state_nxt = ST_PB_PT;
          end
        end else begin
          w_state_nxt = ST_WAIT_PT;
        end
      end

      ST_PB_PT: begin
        round_o   = r_cnt;
        ena_reg_o = 1'b1;
        if (r_cnt == LAST_ROUND) begin
          w_block_idx_nxt = w_block_idx_inc;
          w_state_nxt     = ST_WAIT_PT;
          // Key is pre-added to x1,x2 just before the last block arrives.
          if (w_block_idx_inc == LAST_IDX) begin
            ena_xor_down_o  = 1'b1;
            xor_down_mode_o = MODE_KHI;
          end else begin
            ena_xor_down_o  = 1'b0;
            xor_down_mode_o = MODE_NONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_FINAL: begin
        round_o   = r_cnt;
        ena_reg_o = 1'b1;
        if (r_cnt == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          xor_down_mode_o = MODE_KLO;
          tag_valid_o     = 1'b1;
          w_state_nxt     = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_DONE: begin
        w_cnt_nxt       = 4'd0;
        w_block_idx_nxt = 4'd0;
        w_state_nxt     = ST_IDLE;
      end

      default: begin
        busy_o          = 1'b0;
        w_cnt_nxt       = 4'd0;
        w_block_idx_nxt = 4'd0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// Bench for ascon_ctrl_fsm. Two instances: NB_BLOCKS=4 (a) and NB_BLOCKS=2 (b).
// The reference is a flat list of "active" cycles built from the message
// structure (p12, AD + p6, blocks + p6, last block + p12); each entry says
// whether it is a handshake point. Stall cycles are inserted wherever the
// entry is a handshake and data_valid_i is low.
// Output vector bit order:
//  [17] block_ready [16] select [15:12] round [11] xor_up [10] xor_down
//  [9:8] mode [7] ena_reg [6] cipher_valid [5:2] block_idx [1] tag [0] busy
// ---------------------------------------------------------------------------
module tb_ascon_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;
  logic start_a, dv_a, start_b, dv_b;

  logic       a_br, a_sel, a_xu, a_xd, a_ereg, a_cv, a_tag, a_busy;
  logic [3:0] a_round, a_idx;
  logic [1:0] a_mode;
  logic       b_br, b_sel, b_xu, b_xd, b_ereg, b_cv, b_tag, b_busy;
  logic [3:0] b_round, b_idx;
  logic [1:0] b_mode;

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_BLOCKS(4)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a), .data_valid_i(dv_a),
    .block_ready_o(a_br), .select_o(a_sel), .round_o(a_round),
    .ena_xor_up_o(a_xu), .ena_xor_down_o(a_xd), .xor_down_mode_o(a_mode),
    .ena_reg_o(a_ereg), .cipher_valid_o(a_cv), .block_idx_o(a_idx),
    .tag_valid_o(a_tag), .busy_o(a_busy)
  );

  ascon_ctrl_fsm #(.NB_BLOCKS(2)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b), .data_valid_i(dv_b),
    .block_ready_o(b_br), .select_o(b_sel), .round_o(b_round),
    .ena_xor_up_o(b_xu), .ena_xor_down_o(b_xd), .xor_down_mode_o(b_mode),
    .ena_reg_o(b_ereg), .cipher_valid_o(b_cv), .block_idx_o(b_idx),
    .tag_valid_o(b_tag), .busy_o(b_busy)
  );

  int checks   = 0;
  int failures = 0;

  // reference sequence
  logic [17:0] e_vec[$];
  bit          e_hs[$];
  // recorded run
  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] msk_q[$];
  int          cv_cyc[$];
  int          tag_cyc;
  int          busy_low;
  bit          timed_out;

  function automatic logic [17:0] pack(input int which);
    if (which == 0)
      return {a_br, a_sel, a_round, a_xu, a_xd, a_mode, a_ereg, a_cv, a_idx, a_tag, a_busy};
    else
      return {b_br, b_sel, b_round, b_xu, b_xd, b_mode, b_ereg, b_cv, b_idx, b_tag, b_busy};
  endfunction

  function automatic logic [17:0] mk(input bit br, input bit sel, input int rnd,
                                     input bit xu, input bit xd, input int mode,
                                     input bit ereg, input bit cv, input int idx,
                                     input bit tag, input bit busy);
    logic [3:0] r4;
    logic [3:0] i4;
    logic [1:0] m2;
    r4 = rnd[3:0];
    i4 = idx[3:0];
    m2 = mode[1:0];
    return {br, sel, r4, xu, xd, m2, ereg, cv, i4, tag, busy};
  endfunction

  // Message structure: modes 1=DSEP, 2=KEY_HI, 3=KEY_LO.
  task automatic build_seq(input int nb);
    e_vec.delete();
    e_hs.delete();
    e_vec.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); e_hs.push_back(0);
    for (int r = 1; r <= 11; r++) begin
      e_vec.push_back(mk(0, 0, r, 0, r == 11, (r == 11) ? 3 : 0, 1, 0, 0, 0, 1));
      e_hs.push_back(0);
    end
    for (int r = 6; r <= 11; r++) begin
      e_vec.push_back(mk(r == 6, 0, r, r == 6, r == 11, (r == 11) ? 1 : 0, 1, 0, 0, 0, 1));
      e_hs.push_back(r == 6);
    end
    for (int b = 0; b < nb; b++) begin
      if (b < nb - 1) begin
        for (int r = 6; r <= 11; r++) begin
          bit kh;
          kh = (r == 11) && (b + 1 == nb - 1);
          e_vec.push_back(mk(r == 6, 0, r, r == 6, kh, kh ? 2 : 0, 1, r == 6, b, 0, 1));
          e_hs.push_back(r == 6);
        end
      end else begin
        e_vec.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, b, 0, 1)); e_hs.push_back(1);
        for (int r = 1; r <= 11; r++) begin
          e_vec.push_back(mk(0, 0, r, 0, r == 11, (r == 11) ? 3 : 0, 1, 0, b, r == 11, 1));
          e_hs.push_back(0);
        end
      end
    end
  endtask

  task automatic set_inputs(input int which, input logic st, input logic dv);
    if (which == 0) begin
      start_a = st; dv_a = dv; start_b = 1'b0; dv_b = 1'b0;
    end else begin
      start_b = st; dv_b = dv; start_a = 1'b0; dv_a = 1'b0;
    end
  endtask

  // Drive one message and record observed/expected per cycle (cycle 0 = start).
  // ad_stall forces that many idle cycles at the AD handshake; noise randomises
  // start_i and data_valid_i where they must be ignored; abort_k stops right
  // after sampling that reference entry.
  task automatic drive_message(input int which, input int nb, input int stall_pct,
                               input int ad_stall, input bit noise, input int abort_k);
    int k, cyc, ad_left;
    logic st, dv;
    bit stall;
    build_seq(nb);
    obs_q.delete(); exp_q.delete(); msk_q.delete(); cv_cyc.delete();
    tag_cyc = -1; busy_low = -1; timed_out = 0;
    k = 0; cyc = 0; ad_left = ad_stall;
    while (k < e_vec.size()) begin
      if (cyc >= 2000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      st = (k == 0) ? 1'b1 : (noise ? logic'($urandom_range(1)) : 1'b0);
      if (e_hs[k]) begin
        if (k == 12 && ad_left > 0) begin
          dv = 1'b0;
          ad_left--;
        end else begin
          dv = ($urandom_range(99) >= stall_pct);
        end
      end else begin
        dv = noise ? logic'($urandom_range(1)) : 1'b0;
      end
      set_inputs(which, st, dv);
      @(negedge clk);
      stall = e_hs[k] && !dv;
      obs_q.push_back(pack(which));
      exp_q.push_back(stall ? mk(1, 0, 0, 0, 0, 0, 0, 0, e_vec[k][5:2], 0, 1) : e_vec[k]);
      msk_q.push_back(18'h3ffff);
      if (pack(which) & 18'h2) begin
        if (tag_cyc < 0) tag_cyc = cyc;
      end
      if (pack(which) & 18'h40) cv_cyc.push_back(cyc);
      if (k == abort_k && !stall) return;
      if (!stall) k++;
      cyc++;
    end
    if (timed_out) return;
    // DONE cycle: busy, no controls; block index not constrained here
    @(posedge clk); #1;
    set_inputs(which, noise ? logic'($urandom_range(1)) : 1'b0,
               noise ? logic'($urandom_range(1)) : 1'b0);
    @(negedge clk);
    obs_q.push_back(pack(which));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    msk_q.push_back(18'h3ffc3);
    cyc++;
    // back in IDLE: everything low
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_inputs(which, 1'b0, noise ? logic'($urandom_range(1)) : 1'b0);
      @(negedge clk);
      obs_q.push_back(pack(which));
      exp_q.push_back(18'h0);
      msk_q.push_back(18'h3ffff);
      if (busy_low < 0 && !(pack(which) & 18'h1)) busy_low = cyc;
      cyc++;
    end
    set_inputs(which, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b1; dv_a = 1'b1; start_b = 1'b1; dv_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pack(0) !== 18'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", pack(0), 18'h0);
    end
    checks++;
    if (pack(1) !== 18'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", pack(1), 18'h0);
    end
    start_a = 1'b0; dv_a = 1'b0; start_b = 1'b0; dv_b = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pack(0) !== 18'h0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h exp=%h", pack(0), 18'h0);
    end
  endtask

  task automatic test_nominal_nb4();
    int exp_tag;
    drive_message(0, 4, 0, 0, 0, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL nominal_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL nominal_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    exp_tag = 12 + 6 + 6 * (4 - 1) + 12 - 1;
    checks++;
    if (tag_cyc !== exp_tag) begin failures++; $display("FAIL nominal_tag_cycle got=%0d exp=%0d", tag_cyc, exp_tag); end
    checks++;
    if (busy_low !== exp_tag + 2) begin failures++; $display("FAIL nominal_busy_low got=%0d exp=%0d", busy_low, exp_tag + 2); end
    checks++;
    if (cv_cyc.size() !== 4) begin
      failures++;
      $display("FAIL nominal_cipher_count got=%0d exp=4", cv_cyc.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (cv_cyc[b] !== 18 + 6 * b) begin
          failures++;
          $display("FAIL nominal_cipher_cycle%0d got=%0d exp=%0d", b, cv_cyc[b], 18 + 6 * b);
        end
      end
    end
  endtask

  task automatic test_wait_ad_stall();
    drive_message(0, 4, 0, 5, 0, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL ad_stall_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL ad_stall_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    checks++;
    if (tag_cyc !== 47 + 5) begin failures++; $display("FAIL ad_stall_tag_cycle got=%0d exp=%0d", tag_cyc, 52); end
  endtask

  task automatic test_ignored_inputs();
    drive_message(0, 4, 0, 0, 1, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL ignored_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL ignored_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    checks++;
    if (tag_cyc !== 47) begin failures++; $display("FAIL ignored_tag_cycle got=%0d exp=47", tag_cyc); end
  endtask

  task automatic test_random_stalls(input int which, input int nb, input int runs);
    for (int r = 0; r < runs; r++) begin
      drive_message(which, nb, 40, 0, 1, -1);
      checks++;
      if (timed_out !== 1'b0) begin failures++; $display("FAIL random_timeout run%0d got=%0d exp=0", r, timed_out); end
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          failures++;
          $display("FAIL random_nb%0d_run%0d_cycle%0d got=%h exp=%h", nb, r, i,
                   obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
        end
      end
      checks++;
      if (cv_cyc.size() !== nb) begin
        failures++;
        $display("FAIL random_cipher_count got=%0d exp=%0d", cv_cyc.size(), nb);
      end
    end
  endtask

  task automatic test_reset_mid_final();
    // entry 41 of the NB=4 sequence is FINAL round 5
    drive_message(0, 4, 0, 0, 0, 41);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL pre_abort_cycle%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (pack(0) !== 18'h0) begin failures++; $display("FAIL async_reset_outputs got=%h exp=%h", pack(0), 18'h0); end
    @(negedge clk);
    rst = 1'b0;
    drive_message(0, 4, 0, 0, 0, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL post_abort_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL post_abort_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    checks++;
    if (tag_cyc !== 47) begin failures++; $display("FAIL post_abort_tag_cycle got=%0d exp=47", tag_cyc); end
  endtask

  task automatic test_nb2();
    int exp_tag;
    drive_message(1, 2, 0, 0, 0, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL nb2_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        failures++;
        $display("FAIL nb2_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    exp_tag = 12 + 6 + 6 * (2 - 1) + 12 - 1;
    checks++;
    if (tag_cyc !== exp_tag) begin failures++; $display("FAIL nb2_tag_cycle got=%0d exp=%0d", tag_cyc, exp_tag); end
    checks++;
    if (busy_low !== exp_tag + 2) begin failures++; $display("FAIL nb2_busy_low got=%0d exp=%0d", busy_low, exp_tag + 2); end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; dv_a = 1'b0; start_b = 1'b0; dv_b = 1'b0;
    test_reset();
    test_nominal_nb4();
    test_wait_ad_stall();
    test_ignored_inputs();
    test_random_stalls(0, 4, 3);
    test_reset_mid_final();
    test_nb2();
    test_random_stalls(1, 2, 3);
    // back-to-back messages on the NB=4 instance
    test_nominal_nb4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
